// File: rtl/sm2_product_gen_seq.sv
// sm2_product_gen_seq: iterative 256x256 unsigned multiplier feeding the SM2
// fast reducer. Operand scanning, one DIGIT_W x DIGIT_W partial product per
// cycle, accumulated into a 512-bit register that drives out_p directly.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. in_ready and out_valid depend only on the state register
// (and rst for in_ready), never on in_valid or out_ready. A source must hold
// valid and its data stable until the transfer.
module sm2_product_gen_seq #(
  parameter int DIGIT_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_a,
  input  logic [255:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_p,
  output logic [1:0]   dbg_state_o
);

  localparam int N  = 256 / DIGIT_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [255:0]    a_q, a_d;
  logic [255:0]    b_q, b_d;
  logic [511:0]    acc_q, acc_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;

  logic                   accept;
  logic                   last_step;
  logic [9:0]             a_off;
  logic [9:0]             b_off;
  logic [9:0]             pp_sh;
  logic [DIGIT_W-1:0]     a_dig;
  logic [DIGIT_W-1:0]     b_dig;
  logic [2*DIGIT_W-1:0]   pp;
  logic [511:0]           pp_aligned;

  assign accept    = in_valid && in_ready;
  assign last_step = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));

  // Digit select and weighted partial product for the current (i, j) pair.
  always_comb begin
    a_off      = 10'(DIGIT_W) * 10'(i_q);
    b_off      = 10'(DIGIT_W) * 10'(j_q);
    pp_sh      = 10'(DIGIT_W) * (10'(i_q) + 10'(j_q));
    a_dig      = DIGIT_W'(a_q >> a_off);
    b_dig      = DIGIT_W'(b_q >> b_off);
    pp         = {{DIGIT_W{1'b0}}, a_dig} * {{DIGIT_W{1'b0}}, b_dig};
    pp_aligned = 512'(pp) << pp_sh;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic: accept -> N*N multiply cycles -> hold until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = MUL;
      MUL:     if (last_step) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    in_ready    = (state_q == IDLE) && !rst;
    out_valid   = (state_q == HOLD);
    dbg_state_o = state_q;
  end

  // Datapath next-state: latch operands on accept, accumulate and step digits in MUL.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    i_d   = i_q;
    j_d   = j_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = in_a;
          b_d   = in_b;
          acc_d = '0;
          i_d   = '0;
          j_d   = '0;
        end
      end
      MUL: begin
        // Sum never exceeds 2^512-1, so the carry out of bit 511 is dropped.
        acc_d = acc_q + pp_aligned;
        if (j_q == IW'(N - 1)) begin
          j_d = '0;
          i_d = last_step ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      i_q   <= i_d;
      j_q   <= j_d;
    end
  end

  assign out_p = acc_q;

endmodule

// File: tb/tb_sm2_product_gen_seq.sv
// Bench for sm2_product_gen_seq: directed vector table, multi-cycle corner
// sequences (backpressure, mid-op reset, operand changes) and a random
// back-to-back run checked by a scoreboard fed from the input handshake.
module tb_sm2_product_gen_seq;

  localparam int LAT = 16;
  localparam logic [255:0] SM2_P =
    256'hfffffffeffffffffffffffffffffffffffffffff00000000ffffffffffffffff;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_a;
  logic [255:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_p;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int cyc     = 0;

  logic [511:0] exp_q[$];

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs[8];

  sm2_product_gen_seq #(.DIGIT_W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_p       (out_p),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check512(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(512'(in_a) * 512'(in_b));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_int("sb_unexpected_output", 1, 0);
        end else begin
          check512("sb_product", out_p, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic send(input logic [255:0] a, input logic [255:0] b, output bit ok);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check_int("send_timeout", 0, 1);
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    if (!ok) check_int("out_valid_timeout", 0, 1);
  endtask

  task automatic run_op(input string name, input logic [255:0] a, input logic [255:0] b,
                        input logic [511:0] exp);
    bit ok;
    int lat;
    send(a, b, ok);
    if (ok) begin
      wait_out(lat, ok);
      if (ok) begin
        check_int({name, "_latency"}, lat, LAT);
        check512({name, "_out_p"}, out_p, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_int({name, "_valid_drop"}, int'(out_valid), 0);
        check_int({name, "_ready_back"}, int'(in_ready), 1);
      end
    end
  endtask

  initial begin
    logic [511:0] held;
    logic [511:0] spec_prod;
    logic [255:0] oa, ob;
    bit           ok;
    int           lat;
    int           acc_before;
    int           t_prev;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;

    // directed table
    vecs[0].a   = 256'hc239507105c683242a81052ff641ed69009a084ad5cc937db21646cd34a0ced5;
    vecs[0].b   = 256'hb1bf7ec4080f3c8735f1294ac0db19686bee2e96ab8c71fb7a253666cb66e009;
    vecs[0].exp = 512'(vecs[0].a) * 512'(vecs[0].b);
    vecs[1].a   = {256{1'b1}};
    vecs[1].b   = {256{1'b1}};
    vecs[1].exp = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
    vecs[2].a   = '0;
    vecs[2].b   = 256'hdeadbeef0123456789abcdef00112233445566778899aabbccddeeff01020304;
    vecs[2].exp = '0;
    vecs[3].a   = 256'd3;
    vecs[3].b   = 256'd5;
    vecs[3].exp = 512'd15;
    vecs[4].a   = 256'hffffffffffffffff;
    vecs[4].b   = 256'hffffffffffffffff;
    vecs[4].exp = 512'hfffffffffffffffe0000000000000001;
    vecs[5].a   = {1'b1, 255'b0};
    vecs[5].b   = 256'd2;
    vecs[5].exp = {255'b0, 1'b1, 256'b0};
    vecs[6].a   = {63'b0, 1'b1, 192'b0};
    vecs[6].b   = {63'b0, 1'b1, 192'b0};
    vecs[6].exp = {127'b0, 1'b1, 384'b0};
    vecs[7].a   = {256{1'b1}};
    vecs[7].b   = 256'd1;
    vecs[7].exp = {256'b0, {256{1'b1}}};

    // reset state
    tick();
    tick();
    check_int("rst_in_ready", int'(in_ready), 0);
    check_int("rst_out_valid", int'(out_valid), 0);
    check512("rst_out_p", out_p, '0);
    check_int("rst_state", int'(dbg_state), 0);
    rst = 1'b0;
    #1;
    check_int("post_rst_in_ready", int'(in_ready), 1);

    for (int v = 0; v < 8; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].exp);
    end

    // known SM2 reduction of the first vector's product
    spec_prod = 512'(vecs[0].a) * 512'(vecs[0].b);
    check512("vec0_sm2_reduced", 512'(spec_prod % 512'(SM2_P)),
             512'(256'h35fe79196aab8d8af83f199bfe3b0b694a02b1cc5704893293838bd3258a7593));

    // backpressure: out_ready low 5 cycles, new in_valid pending
    send(256'd7, 256'd9, ok);
    if (ok) begin
      wait_out(lat, ok);
      if (ok) begin
        held       = out_p;
        acc_before = n_acc;
        in_a       = 256'd11;
        in_b       = 256'd13;
        in_valid   = 1'b1;
        for (int k = 0; k < 5; k++) begin
          tick();
          check_int("bp_out_valid", int'(out_valid), 1);
          check512("bp_out_p", out_p, held);
          check_int("bp_in_ready", int'(in_ready), 0);
        end
        check512("bp_value", held, 512'd63);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_int("bp_no_early_accept", n_acc - acc_before, 0);
        check_int("bp_ready_after", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check_int("bp_accept_after", n_acc - acc_before, 1);
        wait_out(lat, ok);
        if (ok) begin
          check512("bp_second_p", out_p, 512'd143);
          out_ready = 1'b1;
          tick();
          out_ready = 1'b0;
        end
      end
    end

    // reset during the 7th multiply cycle
    send(rand256(), rand256(), ok);
    if (ok) begin
      for (int k = 0; k < 6; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_int("mid_rst_state", int'(dbg_state), 0);
      check_int("mid_rst_in_ready", int'(in_ready), 1);
      check_int("mid_rst_out_valid", int'(out_valid), 0);
      check512("mid_rst_out_p", out_p, '0);
      run_op("after_rst", 256'd3, 256'd5, 512'd15);
    end

    // operands changed and in_valid toggled during MUL
    oa         = 256'h123456789abcdef0fedcba9876543210_0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    ob         = 256'h0badf00d_cafebabe_11111111_22222222_33333333_44444444_55555555_66666666;
    acc_before = n_acc;
    send(oa, ob, ok);
    if (ok) begin
      for (int k = 0; k < 10; k++) begin
        in_a     = rand256();
        in_b     = rand256();
        in_valid = k[0];
        tick();
      end
      in_valid = 1'b0;
      wait_out(lat, ok);
      if (ok) begin
        check_int("chg_latency", lat + 10, LAT);
        check512("chg_out_p", out_p, 512'(oa) * 512'(ob));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
      check_int("chg_accepts", n_acc - acc_before, 1);
    end

    // back-to-back random pairs, out_ready and in_valid held high
    acc_before = n_acc;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    t_prev     = -1;
    for (int n = 0; n < 100; n++) begin
      in_a = rand256();
      in_b = rand256();
      ok   = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      if (!ok) begin
        check_int("b2b_timeout", 0, 1);
        break;
      end
      if (t_prev >= 0) check_int("b2b_period", cyc - t_prev, LAT + 2);
      t_prev = cyc;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    out_ready = 1'b0;
    check_int("b2b_accepts", n_acc - acc_before, 100);
    check_int("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
